// File: rtl/serial_pkg.sv
// Shared definitions for the sequence-detector serializer: state encoding,
// default idle level and the bit-counter width helper.
package serial_pkg;

  typedef enum logic {
    OCIOSO       = 1'b0,
    TRANSMITINDO = 1'b1
  } estado_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

  // Counter must hold every frame position 0..n-1 with headroom up to n.
  function automatic int largura_contador(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/registrador_deslocamento.sv
// WIDTH-bit shift register feeding the serializer. On load it keeps the word
// already advanced by one position, because the first bit leaves directly from data_in.
module registrador_deslocamento #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_bit
);

  logic [WIDTH-1:0] shift_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
    end else if (load) begin
      if (MSB_FIRST) shift_reg <= {data_in[WIDTH-2:0], 1'b0};
      else           shift_reg <= {1'b0, data_in[WIDTH-1:1]};
    end else if (shift) begin
      if (MSB_FIRST) shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      else           shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
    end
  end

  assign serial_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

endmodule

// File: rtl/serializador_sequencia.sv
// Parallel-to-serial front end for the 1110 detector, valid/ready load, no gap
// between back-to-back words. Define PARIDADE_EN to append an even-parity bit.
module serializador_sequencia
  import serial_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

`ifdef PARIDADE_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int             CW     = largura_contador(N);
  localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

  estado_t         state_reg;
  logic [CW-1:0]   counter_reg;
  logic            accept;
  logic            shift_en;
  logic            serial_bit;
  logic            first_bit;

  assign load_ready = (state_reg == OCIOSO) ||
                      ((state_reg == TRANSMITINDO) && (counter_reg == ULTIMO));
  assign accept     = load_valid && load_ready;
  assign shift_en   = (state_reg == TRANSMITINDO) && (counter_reg != ULTIMO);
  assign first_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];

  registrador_deslocamento #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_registrador (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .shift      (shift_en),
    .data_in    (data_in),
    .serial_bit (serial_bit)
  );

`ifdef PARIDADE_EN
  localparam logic [CW-1:0] ULTIMO_DADO = CW'(WIDTH - 1);
  logic parity_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      parity_reg <= 1'b0;
    else if (accept) parity_reg <= ^data_in;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= OCIOSO;
      counter_reg <= '0;
      x_out       <= IDLE_LEVEL;
      bit_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        OCIOSO: begin
          if (accept) begin
            state_reg   <= TRANSMITINDO;
            counter_reg <= '0;
            x_out       <= first_bit;
            bit_valid   <= 1'b1;
            busy        <= 1'b1;
          end
        end
        TRANSMITINDO: begin
          if (counter_reg == ULTIMO) begin
            done <= 1'b1;
            if (accept) begin
              // Reload straight after the last bit so no idle bit is inserted.
              counter_reg <= '0;
              x_out       <= first_bit;
            end else begin
              state_reg   <= OCIOSO;
              counter_reg <= '0;
              x_out       <= IDLE_LEVEL;
              bit_valid   <= 1'b0;
              busy        <= 1'b0;
            end
          end else begin
            counter_reg <= counter_reg + CW'(1);
`ifdef PARIDADE_EN
            x_out <= (counter_reg == ULTIMO_DADO) ? parity_reg : serial_bit;
`else
            x_out <= serial_bit;
`endif
          end
        end
        default: begin
          state_reg   <= OCIOSO;
          counter_reg <= '0;
          x_out       <= IDLE_LEVEL;
          bit_valid   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializador_sequencia.sv
// Scoreboard bench for serializador_sequencia: an MSB-first and an LSB-first
// instance share stimulus; expected bits are queued at accept and popped per valid cycle.
module tb_serializador_sequencia;

  localparam int   W    = 4;
`ifdef PARIDADE_EN
  localparam int   N    = W + 1;
`else
  localparam int   N    = W;
`endif
  localparam logic IDLE = 1'b0;

  typedef struct packed {
    logic last;
    logic b_msb;
    logic b_lsb;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;

  logic ready_m, x_m, bv_m, busy_m, done_m;
  logic ready_l, x_l, bv_l, busy_l, done_l;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  bit   done_pending = 1'b0;

  always #5 clock = ~clock;

  serializador_sequencia #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_m), .x_out(x_m), .bit_valid(bv_m), .busy(busy_m), .done(done_m)
  );

  serializador_sequencia #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE)) dut_lsb (
    .clock(clock), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_l), .x_out(x_l), .bit_valid(bv_l), .busy(busy_l), .done(done_l)
  );

  task automatic verifica(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b, expected %b", tag, $time, obs, exp);
  endtask

  task automatic push_word(input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b_msb = w[W-1-i];
      e.b_lsb = w[i];
      e.last  = (i == N - 1);
      sb.push_back(e);
    end
`ifdef PARIDADE_EN
    e.b_msb = ^w;
    e.b_lsb = ^w;
    e.last  = 1'b1;
    sb.push_back(e);
`endif
    $display("accepted word %b at %0t", w, $time);
  endtask

  // Present a word and hold it until the handshake completes (bounded wait).
  task automatic send(input logic [W-1:0] w);
    int espera = 0;
    @(negedge clock);
    data_in    = w;
    load_valid = 1'b1;
    while (!ready_m && espera < 50) begin
      @(negedge clock);
      espera++;
    end
    verifica("accept_timeout", ready_m, 1'b1);
    if (ready_m) begin
      @(posedge clock);
      #1;
      push_word(w);
    end
    load_valid = 1'b0;
  endtask

  logic m_exp_done, m_exp_bv, m_exp_ready, m_em, m_el;
  exp_t m_e;

  always @(negedge clock) begin
    if (reset && mon_en) begin
      m_exp_done   = done_pending;
      done_pending = 1'b0;
      if (sb.size() > 0) begin
        m_e         = sb.pop_front();
        m_exp_bv    = 1'b1;
        m_exp_ready = m_e.last;
        m_em        = m_e.b_msb;
        m_el        = m_e.b_lsb;
        if (m_e.last) done_pending = 1'b1;
      end else begin
        m_exp_bv    = 1'b0;
        m_exp_ready = 1'b1;
        m_em        = IDLE;
        m_el        = IDLE;
      end
      verifica("x_msb",     x_m,     m_em);
      verifica("x_lsb",     x_l,     m_el);
      verifica("bv_msb",    bv_m,    m_exp_bv);
      verifica("bv_lsb",    bv_l,    m_exp_bv);
      verifica("busy_msb",  busy_m,  m_exp_bv);
      verifica("busy_lsb",  busy_l,  m_exp_bv);
      verifica("done_msb",  done_m,  m_exp_done);
      verifica("done_lsb",  done_l,  m_exp_done);
      verifica("ready_msb", ready_m, m_exp_ready);
      verifica("ready_lsb", ready_l, m_exp_ready);
    end
  end

  initial begin
    int t;
    // Reset state
    repeat (2) @(negedge clock);
    verifica("rst_x",     x_m,     IDLE);
    verifica("rst_bv",    bv_m,    1'b0);
    verifica("rst_busy",  busy_m,  1'b0);
    verifica("rst_done",  done_m,  1'b0);
    verifica("rst_ready", ready_m, 1'b1);
    #3 reset = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clock);

    // Single word 1110, then back-to-back 1011 / 0111
    send(4'b1110);
    repeat (N + 2) @(negedge clock);
    send(4'b1011);
    send(4'b0111);
    repeat (N + 2) @(negedge clock);

    // LSB-first instance sees 0001 as 1,0,0,0
    send(4'b0001);
    repeat (N + 2) @(negedge clock);

    // Load attempt while a word is in flight must be ignored
    send(4'b1001);
    @(negedge clock);
    @(negedge clock);
    data_in    = 4'b1111;
    load_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    load_valid = 1'b0;
    repeat (N + 2) @(negedge clock);

    // Asynchronous reset in the middle of a word
    send(4'b1010);
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    sb.delete();
    done_pending = 1'b0;
    #1;
    verifica("midrst_x_msb", x_m,     IDLE);
    verifica("midrst_x_lsb", x_l,     IDLE);
    verifica("midrst_bv",    bv_m,    1'b0);
    verifica("midrst_busy",  busy_m,  1'b0);
    verifica("midrst_done",  done_m,  1'b0);
    verifica("midrst_ready", ready_m, 1'b1);
    repeat (2) @(negedge clock);
    #3 reset = 1'b1;
    repeat (2) @(negedge clock);
    send(4'b1110);

    t = 0;
    while (sb.size() > 0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    verifica("drain", sb.size() == 0, 1'b1);
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
